mfcc_window_buffer: RTL

- Downstream neighbour of the MFCC accelerator. Consumes the serial coefficient stream (mfcc_feature/mfcc_valid) and groups it into frames of NUM_COEFFS coefficients.
- Keeps a sliding window of the most recent NUM_FRAMES frames.
- On every new completed frame, once the window is full, streams the whole window oldest-first to the keyword classifier over a valid/ready interface.

---
 rtl/mfcc_pkg.sv | 15 +
 rtl/mfcc_window_buffer_if.sv | 12 +
 rtl/mfcc_feat_ram.sv | 27 ++
 rtl/mfcc_window_buffer.sv | 145 ++++++++++++++
 4 files changed

// File: rtl/mfcc_pkg.sv
// Shared defaults and types for the MFCC window buffer.
package mfcc_pkg;
    localparam int COEF_W_DFLT     = 16;
    localparam int NUM_COEFFS_DFLT = 13;
    localparam int NUM_FRAMES_DFLT = 16;

    typedef enum logic {IDLE, READ} state_t;

    // Words per emitted window.
    function automatic int win_len(input int num_frames, input int num_coeffs);
        return num_frames * num_coeffs;
    endfunction

    localparam int WIN_LEN_DFLT = win_len(NUM_FRAMES_DFLT, NUM_COEFFS_DFLT);
endpackage

// File: rtl/mfcc_window_buffer_if.sv
// Valid/ready window stream towards the keyword classifier.
interface mfcc_window_buffer_if #(
    parameter int COEF_W = 16
) ();
    logic [COEF_W-1:0] feat_out;
    logic              feat_valid;
    logic              feat_ready;
    logic              feat_last;

    modport master (output feat_out, feat_valid, feat_last, input feat_ready);
    modport slave  (input feat_out, feat_valid, feat_last, output feat_ready);
endinterface

// File: rtl/mfcc_feat_ram.sv
// Simple dual-port RAM: one write port, one registered read port with enable.
module mfcc_feat_ram #(
    parameter int W     = 16,
    parameter int DEPTH = 221,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [W-1:0]  wdata,
    input  logic          re,
    input  logic [AW-1:0] raddr,
    output logic [W-1:0]  rdata
);
    logic [W-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) mem[waddr] <= wdata;
    end

    // rdata doubles as the output register: it holds while re is low.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)     rdata <= '0;
        else if (re) rdata <= mem[raddr];
    end
endmodule

// File: rtl/mfcc_window_buffer.sv
// Frames the serial MFCC stream and, after every new frame once full, dumps the
// most recent NUM_FRAMES frames oldest-first over a valid/ready stream.
module mfcc_window_buffer
    import mfcc_pkg::*;
#(
    parameter int COEF_W     = COEF_W_DFLT,
    parameter int NUM_COEFFS = NUM_COEFFS_DFLT,
    parameter int NUM_FRAMES = NUM_FRAMES_DFLT
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [COEF_W-1:0]     mfcc_feature,
    input  logic                  mfcc_valid,
    mfcc_window_buffer_if.master  feat,
    output logic                  window_ready,
    output logic                  overflow,
    output logic [15:0]           window_count
);
    localparam int SLOTS = NUM_FRAMES + 1;
    localparam int DEPTH = SLOTS * NUM_COEFFS;
    localparam int WIN   = win_len(NUM_FRAMES, NUM_COEFFS);
    localparam int AW    = $clog2(DEPTH);
    localparam int CW    = $clog2(NUM_COEFFS);
    localparam int SW    = $clog2(SLOTS);
    localparam int FW    = $clog2(NUM_FRAMES + 1);
    localparam int IW    = $clog2(WIN + 1);
    localparam logic [CW-1:0] LAST_COEF = CW'(NUM_COEFFS - 1);
    localparam logic [SW-1:0] LAST_SLOT = SW'(SLOTS - 1);
    localparam logic [FW-1:0] FULL      = FW'(NUM_FRAMES);
    localparam logic [IW-1:0] WIN_END   = IW'(WIN);
    localparam logic [IW-1:0] WIN_LAST  = IW'(WIN - 1);
    localparam logic [AW-1:0] NC_A      = AW'(NUM_COEFFS);

    function automatic logic [SW-1:0] slot_inc(input logic [SW-1:0] s);
        return (s == LAST_SLOT) ? '0 : s + 1'b1;
    endfunction

    state_t           state, state_nxt;
    logic [CW-1:0]    coef_cnt, rd_coef;
    logic [SW-1:0]    wr_slot, wr_slot_nxt, rd_start, rd_slot;
    logic [FW-1:0]    frames_stored, frames_nxt;
    logic [IW-1:0]    rd_idx;
    logic             pending, fv, fl;
    logic             drop, wr_en, commit, commit_full, start, rd_en, accept, last_acc;
    logic [AW-1:0]    waddr, raddr;
    logic [COEF_W-1:0] rdata;

    // Once the spare slot has been filled during a dump, wr_slot lands on the
    // oldest frame still being read, so further input must be discarded.
    assign drop        = mfcc_valid && (state == READ) && (wr_slot == rd_start);
    assign wr_en       = mfcc_valid && !drop;
    assign commit      = wr_en && (coef_cnt == LAST_COEF);
    assign wr_slot_nxt = commit ? slot_inc(wr_slot) : wr_slot;
    assign frames_nxt  = (commit && frames_stored != FULL) ? frames_stored + 1'b1 : frames_stored;
    assign commit_full = commit && (frames_nxt == FULL);
    assign start       = (state == IDLE) && (pending || commit_full);
    assign accept      = fv && feat.feat_ready;
    assign last_acc    = accept && fl;
    assign rd_en       = (state == READ) && (rd_idx != WIN_END) && (!fv || feat.feat_ready);

    assign waddr = AW'(wr_slot) * NC_A + AW'(coef_cnt);
    assign raddr = AW'(rd_slot) * NC_A + AW'(rd_coef);

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start) state_nxt = READ;
            READ:    if (last_acc) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            coef_cnt      <= '0;
            wr_slot       <= '0;
            frames_stored <= '0;
            pending       <= 1'b0;
            overflow      <= 1'b0;
        end else begin
            if (wr_en) coef_cnt <= commit ? '0 : coef_cnt + 1'b1;
            wr_slot       <= wr_slot_nxt;
            frames_stored <= frames_nxt;
            if (start)            pending <= 1'b0;
            else if (commit_full) pending <= 1'b1;
            if (drop) overflow <= 1'b1;
        end
    end

    // The oldest window frame sits just past the spare slot wr_slot points at.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_start     <= '0;
            rd_slot      <= '0;
            rd_coef      <= '0;
            rd_idx       <= '0;
            fv           <= 1'b0;
            fl           <= 1'b0;
            window_count <= '0;
        end else begin
            if (start) begin
                rd_start <= slot_inc(wr_slot_nxt);
                rd_slot  <= slot_inc(wr_slot_nxt);
                rd_coef  <= '0;
                rd_idx   <= '0;
            end else if (rd_en) begin
                rd_idx <= rd_idx + 1'b1;
                if (rd_coef == LAST_COEF) begin
                    rd_coef <= '0;
                    rd_slot <= slot_inc(rd_slot);
                end else begin
                    rd_coef <= rd_coef + 1'b1;
                end
            end
            if (rd_en) begin
                fv <= 1'b1;
                fl <= (rd_idx == WIN_LAST);
            end else if (accept) begin
                fv <= 1'b0;
            end
            if (last_acc) window_count <= window_count + 1'b1;
        end
    end

    mfcc_feat_ram #(.W(COEF_W), .DEPTH(DEPTH), .AW(AW)) u_ram (
        .clk   (clk),
        .rst   (rst),
        .we    (wr_en),
        .waddr (waddr),
        .wdata (mfcc_feature),
        .re    (rd_en),
        .raddr (raddr),
        .rdata (rdata)
    );

    assign feat.feat_out   = rdata;
    assign feat.feat_valid = fv;
    assign feat.feat_last  = fl;
    assign window_ready    = (frames_stored == FULL);
endmodule
